// File: rtl/voting_ballot_collector_n2_m3.sv
// Ballot collector for the 4-candidate, 8-voter tally: gathers one ballot per voter,
// drops duplicates, and presents the packed round to the downstream stage.
module voting_ballot_collector_n2_m3 (
    input  logic        clk,
    input  logic        rst,
    input  logic        ballot_valid,
    output logic        ballot_ready,
    input  logic [2:0]  ballot_id,
    input  logic [1:0]  ballot_vote,
    input  logic        abort,
    output logic [15:0] p_input,
    output logic        round_valid,
    input  logic        round_ready,
    output logic [7:0]  voted_mask,
    output logic        dup_err,
    output logic [7:0]  round_count
);

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [15:0] p_next;
    logic [7:0]  mask_next;
    logic [7:0]  count_next;
    logic        dup_next;

    logic        accept;
    logic        already_voted;
    logic        release_round;
    logic [7:0]  id_onehot;
    logic [3:0]  slot_lsb;

    assign ballot_ready  = (state == COLLECT);
    assign round_valid   = (state == PRESENT);

    assign accept        = ballot_valid & ballot_ready & ~abort;
    assign already_voted = voted_mask[ballot_id];
    assign release_round = round_valid & round_ready & ~abort;
    assign id_onehot     = 8'b1 << ballot_id;
    assign slot_lsb      = {ballot_id, 1'b0};

    // NOTE: every variable gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_next = state;
        p_next     = p_input;
        mask_next  = voted_mask;
        count_next = round_count;
        dup_next   = 1'b0;

        if (abort) begin
            state_next = COLLECT;
            p_next     = 16'h0000;
            mask_next  = 8'h00;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept && already_voted) begin
                        dup_next = 1'b1;
                    end else if (accept) begin
                        p_next[slot_lsb +: 2] = ballot_vote;
                        mask_next             = voted_mask | id_onehot;
                        if ((voted_mask | id_onehot) == 8'hFF) begin
                            state_next = PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (release_round) begin
                        state_next = COLLECT;
                        p_next     = 16'h0000;
                        mask_next  = 8'h00;
                        count_next = round_count + 8'd1;
                    end
                end
                default: state_next = COLLECT;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_input     <= 16'h0000;
            voted_mask  <= 8'h00;
            dup_err     <= 1'b0;
            round_count <= 8'h00;
        end else begin
            p_input     <= p_next;
            voted_mask  <= mask_next;
            dup_err     <= dup_next;
            round_count <= count_next;
        end
    end

endmodule

// File: tb/tb_voting_ballot_collector_n2_m3.sv
// Directed self-checking bench for voting_ballot_collector_n2_m3.
module tb_voting_ballot_collector_n2_m3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ballot_valid;
    logic        ballot_ready;
    logic [2:0]  ballot_id;
    logic [1:0]  ballot_vote;
    logic        abort;
    logic [15:0] p_input;
    logic        round_valid;
    logic        round_ready;
    logic [7:0]  voted_mask;
    logic        dup_err;
    logic [7:0]  round_count;

    int n_checks = 0;
    int n_fail   = 0;

    voting_ballot_collector_n2_m3 dut (
        .clk          (clk),
        .rst          (rst),
        .ballot_valid (ballot_valid),
        .ballot_ready (ballot_ready),
        .ballot_id    (ballot_id),
        .ballot_vote  (ballot_vote),
        .abort        (abort),
        .p_input      (p_input),
        .round_valid  (round_valid),
        .round_ready  (round_ready),
        .voted_mask   (voted_mask),
        .dup_err      (dup_err),
        .round_count  (round_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a full round of ballots: ids taken from ids[], all voting the given votes.
    task automatic full_round(input logic [2:0] ids [8], input logic [1:0] votes [8]);
        for (int i = 0; i < 8; i++) begin
            ballot_valid = 1'b1;
            ballot_id    = ids[i];
            ballot_vote  = votes[i];
            tick();
        end
        ballot_valid = 1'b0;
    endtask

    logic [2:0] seq_ids  [8];
    logic [2:0] perm_ids [8];
    logic [1:0] votes_a  [8];
    logic [1:0] votes_2  [8];
    logic [1:0] votes_1  [8];
    logic [7:0] count_before;

    initial begin
        for (int i = 0; i < 8; i++) begin
            seq_ids[i] = 3'(i);
            votes_a[i] = 2'(i % 4);
            votes_2[i] = 2'd2;
            votes_1[i] = 2'd1;
        end
        perm_ids = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};

        rst          = 1'b1;
        ballot_valid = 1'b0;
        ballot_id    = 3'd0;
        ballot_vote  = 2'd0;
        abort        = 1'b0;
        round_ready  = 1'b0;
        tick();
        tick();
        check("rst_ready", ballot_ready, 1);
        check("rst_rvalid", round_valid, 0);
        check("rst_p", p_input, 16'h0000);
        check("rst_mask", voted_mask, 8'h00);
        check("rst_dup", dup_err, 0);
        check("rst_count", round_count, 8'h00);
        rst = 1'b0;
        tick();

        // Round 1: in-order ids, votes 0,1,2,3,... with immediate release.
        round_ready = 1'b1;
        full_round(seq_ids, votes_a);
        check("r1_rvalid", round_valid, 1);
        check("r1_ready_low", ballot_ready, 0);
        check("r1_p", p_input, 16'hE4E4);
        check("r1_mask", voted_mask, 8'hFF);
        check("r1_count_pre", round_count, 8'd0);
        tick();
        check("r1_rvalid_drop", round_valid, 0);
        check("r1_ready_back", ballot_ready, 1);
        check("r1_p_clr", p_input, 16'h0000);
        check("r1_mask_clr", voted_mask, 8'h00);
        check("r1_count", round_count, 8'd1);

        // Round 2: permuted ids, held in PRESENT while ballots keep arriving.
        round_ready = 1'b0;
        full_round(perm_ids, votes_2);
        check("r2_p", p_input, 16'hAAAA);
        ballot_valid = 1'b1;
        ballot_id    = 3'd0;
        ballot_vote  = 2'd1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("r2_hold_p", p_input, 16'hAAAA);
            check("r2_hold_rvalid", round_valid, 1);
            check("r2_hold_dup", dup_err, 0);
        end
        ballot_valid = 1'b0;
        round_ready  = 1'b1;
        tick();
        check("r2_released", round_valid, 0);
        check("r2_count", round_count, 8'd2);
        check("r2_p_clr", p_input, 16'h0000);

        // Duplicate ballot from voter 3.
        ballot_valid = 1'b1;
        ballot_id    = 3'd3;
        ballot_vote  = 2'd1;
        tick();
        check("dup_first_no_err", dup_err, 0);
        ballot_vote = 2'd2;
        tick();
        check("dup_err", dup_err, 1);
        check("dup_slot", p_input[7:6], 2'b01);
        check("dup_mask", voted_mask, 8'h08);
        tick();
        check("dup_b2b", dup_err, 1);
        ballot_valid = 1'b0;
        tick();
        check("dup_clear", dup_err, 0);
        check("dup_p", p_input, 16'h0040);

        // Abort clears a partial round without counting it.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort1_mask", voted_mask, 8'h00);
        check("abort1_count", round_count, 8'd2);

        for (int i = 0; i < 5; i++) begin
            ballot_valid = 1'b1;
            ballot_id    = 3'(i);
            ballot_vote  = 2'd3;
            tick();
        end
        check("part_mask", voted_mask, 8'h1F);
        check("part_p", p_input, 16'h03FF);
        ballot_id = 3'd5;
        abort     = 1'b1;
        tick();
        abort        = 1'b0;
        ballot_valid = 1'b0;
        check("abort2_mask", voted_mask, 8'h00);
        check("abort2_p", p_input, 16'h0000);
        check("abort2_count", round_count, 8'd2);
        check("abort2_ready", ballot_ready, 1);

        round_ready = 1'b1;
        full_round(seq_ids, votes_1);
        check("fresh_p", p_input, 16'h5555);
        check("fresh_rvalid", round_valid, 1);
        tick();
        check("fresh_count", round_count, 8'd3);

        // Abort in PRESENT with round_ready high: round dropped, not counted.
        round_ready = 1'b0;
        full_round(seq_ids, votes_2);
        round_ready = 1'b1;
        abort       = 1'b1;
        tick();
        abort = 1'b0;
        check("abort3_rvalid", round_valid, 0);
        check("abort3_count", round_count, 8'd3);
        check("abort3_p", p_input, 16'h0000);

        // Run to 256 completed rounds so the counter wraps.
        for (int r = 3; r < 255; r++) begin
            full_round(seq_ids, votes_a);
            tick();
        end
        count_before = round_count;
        check("wrap_pre", count_before, 8'd255);
        full_round(seq_ids, votes_a);
        tick();
        check("wrap", round_count, 8'd0);

        // Asynchronous reset mid-cycle after 4 ballots.
        for (int i = 0; i < 4; i++) begin
            ballot_valid = 1'b1;
            ballot_id    = 3'(i);
            ballot_vote  = 2'd2;
            tick();
        end
        ballot_valid = 1'b0;
        full_round(seq_ids, votes_a);
        tick();
        check("pre_arst_count", round_count, 8'd1);
        for (int i = 0; i < 4; i++) begin
            ballot_valid = 1'b1;
            ballot_id    = 3'(i);
            ballot_vote  = 2'd2;
            tick();
        end
        ballot_valid = 1'b0;
        check("pre_arst_mask", voted_mask, 8'h0F);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mask", voted_mask, 8'h00);
        check("arst_p", p_input, 16'h0000);
        check("arst_count", round_count, 8'h00);
        check("arst_ready", ballot_ready, 1);
        check("arst_rvalid", round_valid, 0);
        check("arst_dup", dup_err, 0);
        tick();
        rst = 1'b0;
        tick();
        full_round(seq_ids, votes_2);
        check("post_arst_p", p_input, 16'hAAAA);
        tick();
        check("post_arst_count", round_count, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voting_ballot_collector_n2_m3.md
# voting_ballot_collector_N2_M3

Sequential ballot-collection stage that sits directly upstream of the combinational `voting_N2_M3` tally. It does four things:

- accepts one 2-bit ballot per cycle from each of 8 voters over a valid/ready handshake;
- rejects duplicate ballots from the same voter;
- assembles the packed 16-bit `p_input` word;
- presents that word, held stable, with a valid/ready handshake to the downstream stage, which samples the voter's `o` output.

## Interface
Parameters (fixed for this variant; the module is not parameterised):
- N, 2, ballot width in bits (4 candidates)
- M, 3, voter-ID width (8 voters)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ballot_valid  in  1  ballot offered
- ballot_ready  out  1  collector can accept a ballot
- ballot_id  in  3  voter index 0..7
- ballot_vote  in  2  candidate index 0..3
- abort  in  1  synchronous round abort
- p_input  out  16  packed ballots; voter i occupies bits [2i+1:2i]; feeds `voting_N2_M3.p_input`
- round_valid  out  1  p_input holds a complete round
- round_ready  in  1  downstream consumed the round
- voted_mask  out  8  bit i set once voter i's ballot has been stored
- dup_err  out  1  one-cycle pulse: a duplicate ballot was dropped
- round_count  out  8  completed rounds, wraps 255 -> 0

## Operation
- FSM states:
  - COLLECT: the only state that accepts ballots.
  - PRESENT: a complete round is held for the downstream stage.
- Output encoding:
  - ballot_ready = (state == COLLECT).
  - round_valid = (state == PRESENT).
  - Both are decoded from the registered state only; neither depends combinationally on any input.
- Accept = ballot_valid & ballot_ready & ~abort.
- On accept with voted_mask[ballot_id] == 0:
  - p_input[2*id+1:2*id] <= ballot_vote;
  - voted_mask[id] <= 1.
- On accept with voted_mask[ballot_id] == 1:
  - the ballot is dropped; p_input and voted_mask are unchanged;
  - dup_err = 1 for the next cycle.
- COLLECT -> PRESENT: when an accept sets the last clear mask bit (mask becomes 8'hFF).
- In PRESENT:
  - p_input and voted_mask are frozen;
  - ballot_valid is ignored and never generates dup_err.
- PRESENT -> COLLECT: on round_valid & round_ready & ~abort. On that edge:
  - p_input <= 0 and voted_mask <= 0;
  - round_count increments modulo 256.
- abort, in either state:
  - next edge: state <= COLLECT, p_input <= 0, voted_mask <= 0, dup_err <= 0;
  - round_count is unchanged.
- abort takes priority over any simultaneous ballot accept or round handshake; the ballot is lost and the round is not counted.
- Voters may vote in any order; ballot_id values need not be contiguous in time.

## Timing
- Reset values (held while rst = 1):
  - state COLLECT
  - ballot_ready = 1
  - round_valid = 0
  - p_input = 16'h0000
  - voted_mask = 8'h00
  - dup_err = 0
  - round_count = 8'h00
- Storage latency: a ballot accepted at edge k appears in p_input and voted_mask after edge k.
- Round completion: if the 8th distinct ballot is accepted at edge k, round_valid = 1 and ballot_ready = 0 from edge k onward.
- Round release: if the handshake occurs at edge m, round_valid = 0, ballot_ready = 1 and p_input = 0 after edge m.
- Minimum round period is 9 cycles (8 accepts plus 1 present cycle, when round_ready is held high).
- p_input is glitch-free and stable for every cycle in which round_valid = 1. The downstream stage samples `o` in the handshake cycle.
- dup_err is registered: high exactly one cycle, the cycle after the offending edge. Back-to-back duplicates give back-to-back pulses.
- Reset asserted mid-round clears everything immediately (asynchronously). Collection restarts from an empty mask after rst is released.

## Test plan
- Reset, then ids 0..7 with votes 0,1,2,3,0,1,2,3 on consecutive cycles, round_ready = 1:
  - p_input = 16'hE4E4 with round_valid = 1 for exactly one cycle;
  - round_count 0 -> 1;
  - ballot_ready low for exactly that one cycle.
- Ids offered in order 7,3,0,5,1,6,2,4, all voting 2, round_ready = 0 for 5 cycles:
  - p_input = 16'hAAAA held stable;
  - ballot_valid during PRESENT is ignored;
  - release on the first cycle round_ready = 1.
- id 3 votes 1, then id 3 votes 2:
  - dup_err pulses once;
  - p_input[7:6] stays 2'b01;
  - voted_mask = 8'h08.
- 5 distinct ballots, then abort together with a valid 6th ballot:
  - next cycle voted_mask = 0, p_input = 0;
  - round_count unchanged;
  - a full fresh round then completes normally.
- 256 completed rounds: round_count wraps to 8'h00.
- rst pulsed asynchronously mid-cycle after 4 ballots: all outputs return to their reset values without a clock edge.
